// File: rtl/xbar_sched.sv
// rtl/xbar_sched.sv - per-slave transaction-locking round-robin scheduler for a 2x2 crossbar
module xbar_sched #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       m_req1,
    input  logic       m_req2,
    input  logic       m_a31_1,
    input  logic       m_a31_2,
    input  logic       s_ack1,
    input  logic       s_ack2,
    output logic [1:0] s_sel1,
    output logic [1:0] s_sel2,
    output logic [1:0] m_sel1,
    output logic [1:0] m_sel2,
    output logic       m_err1,
    output logic       m_err2,
    output logic [1:0] busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic [TO_W-1:0] WD_LAST = TO_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    // Index k holds slave k+1; owner/rr bit 0 means master 1, 1 means master 2.
    state_t [1:0]           state_q, state_d;
    logic   [1:0]           owner_q, owner_d;
    logic   [1:0]           rr_q, rr_d;
    logic   [1:0][TO_W-1:0] wd_q, wd_d;

    logic [1:0] req;
    logic [1:0] a31;
    logic [1:0] ack;
    logic [1:0] elig;

    assign req = {m_req2, m_req1};
    assign a31 = {m_a31_2, m_a31_1};
    assign ack = {s_ack2, s_ack1};

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        elig    = 2'b00;
        for (int k = 0; k < 2; k++) begin
            // Slave 1 is addressed by a31=1, slave 2 by a31=0.
            elig = req & ~(a31 ^ {2{k == 0}});
            case (state_q[k])
                ST_IDLE: begin
                    if (elig != 2'b00) begin
                        state_d[k] = ST_GRANT;
                        owner_d[k] = (elig == 2'b11) ? rr_q[k] : elig[1];
                        rr_d[k]    = ~owner_d[k];
                        wd_d[k]    = '0;
                    end
                end
                ST_GRANT: begin
                    // Ack takes priority over both abort and watchdog expiry.
                    if (ack[k] || !req[owner_q[k]]) begin
                        state_d[k] = ST_IDLE;
                    end else if (TIMEOUT != 0 && wd_q[k] == WD_LAST) begin
                        state_d[k] = ST_ERR;
                    end else begin
                        wd_d[k] = wd_q[k] + TO_W'(1);
                    end
                end
                default: state_d[k] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q[0] <= ST_IDLE;
            state_q[1] <= ST_IDLE;
            owner_q    <= 2'b00;
            rr_q       <= 2'b00;
            wd_q       <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
        end
    end

    logic [1:0] granted;
    logic [1:0] erring;

    assign granted = {state_q[1] == ST_GRANT, state_q[0] == ST_GRANT};
    assign erring  = {state_q[1] == ST_ERR,   state_q[0] == ST_ERR};

    assign s_sel1 = granted[0] ? (owner_q[0] ? 2'b10 : 2'b01) : 2'b00;
    assign s_sel2 = granted[1] ? (owner_q[1] ? 2'b10 : 2'b01) : 2'b00;

    // Slave 1 wins if both slaves claim the same owner.
    assign m_sel1 = (granted[0] && !owner_q[0]) ? 2'b01 :
                    (granted[1] && !owner_q[1]) ? 2'b10 : 2'b00;
    assign m_sel2 = (granted[0] &&  owner_q[0]) ? 2'b01 :
                    (granted[1] &&  owner_q[1]) ? 2'b10 : 2'b00;

    assign m_err1 = (erring[0] && !owner_q[0]) || (erring[1] && !owner_q[1]);
    assign m_err2 = (erring[0] &&  owner_q[0]) || (erring[1] &&  owner_q[1]);

    assign busy = {state_q[1] != ST_IDLE, state_q[0] != ST_IDLE};

endmodule

// File: tb/tb_xbar_sched.sv
// tb/tb_xbar_sched.sv - vector-table and scoreboard bench for xbar_sched
module tb_xbar_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       m_req1 = 1'b0;
    logic       m_req2 = 1'b0;
    logic       m_a31_1 = 1'b0;
    logic       m_a31_2 = 1'b0;
    logic       s_ack1 = 1'b0;
    logic       s_ack2 = 1'b0;
    logic [1:0] s_sel1;
    logic [1:0] s_sel2;
    logic [1:0] m_sel1;
    logic [1:0] m_sel2;
    logic       m_err1;
    logic       m_err2;
    logic [1:0] busy;

    xbar_sched #(.TIMEOUT(4), .TO_W(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .m_req1  (m_req1),
        .m_req2  (m_req2),
        .m_a31_1 (m_a31_1),
        .m_a31_2 (m_a31_2),
        .s_ack1  (s_ack1),
        .s_ack2  (s_ack2),
        .s_sel1  (s_sel1),
        .s_sel2  (s_sel2),
        .m_sel1  (m_sel1),
        .m_sel2  (m_sel2),
        .m_err1  (m_err1),
        .m_err2  (m_err2),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Output word: {s_sel1, s_sel2, m_sel1, m_sel2, m_err1, m_err2, busy}
    wire logic [11:0] outs_w = {s_sel1, s_sel2, m_sel1, m_sel2, m_err1, m_err2, busy};

    localparam logic [11:0] FULL  = 12'hFFF;
    localparam logic [11:0] EMASK = 12'h30C;

    typedef struct {
        logic [6:0]  stim;
        logic [11:0] exp;
        logic [11:0] mask;
        string       name;
    } vec_t;

    vec_t table_q[$];
    vec_t sb_q[$];
    int   total  = 0;
    int   passed = 0;

    function automatic logic [6:0] st(input bit rst, input bit r1, input bit r2,
                                      input bit a1, input bit a2, input bit k1, input bit k2);
        return {rst, r1, r2, a1, a2, k1, k2};
    endfunction

    function automatic logic [11:0] mk(input logic [1:0] s1, input logic [1:0] s2,
                                       input logic [1:0] m1, input logic [1:0] m2,
                                       input logic e1, input logic e2, input logic [1:0] b);
        return {s1, s2, m1, m2, e1, e2, b};
    endfunction

    function automatic vec_t mkv(input logic [6:0] stim, input logic [11:0] exp,
                                 input logic [11:0] mask, input string name);
        vec_t v;
        v.stim = stim;
        v.exp  = exp;
        v.mask = mask;
        v.name = name;
        return v;
    endfunction

    function automatic void add(input logic [6:0] stim, input logic [11:0] exp,
                                input logic [11:0] mask, input string name);
        table_q.push_back(mkv(stim, exp, mask, name));
    endfunction

    task automatic check(input string name, input logic [11:0] act,
                         input logic [11:0] exp, input logic [11:0] mask);
        total++;
        if ((act & mask) !== (exp & mask))
            $display("FAIL %s: got %03h expected %03h (mask %03h)", name, act, exp, mask);
        else
            passed++;
    endtask

    task automatic apply(input vec_t v);
        vec_t e;
        {reset, m_req1, m_req2, m_a31_1, m_a31_2, s_ack1, s_ack2} = v.stim;
        sb_q.push_back(v);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check(e.name, outs_w, e.exp, e.mask);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [11:0] g1;
        logic [11:0] g2;
        logic [11:0] zero;
        g1   = mk(2'b01, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 2'b01);
        g2   = mk(2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 2'b01);
        zero = 12'h000;

        add(st(1,0,0,0,0,0,0), zero, FULL, "reset_state");
        add(st(1,0,0,0,0,0,0), zero, FULL, "reset_state");

        // Single transaction, ack three cycles after the grant.
        add(st(0,1,0,1,0,0,0), g1,   FULL, "a_grant");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "a_hold");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "a_hold");
        add(st(0,1,0,1,0,1,0), zero, FULL, "a_ack_release");
        add(st(0,0,0,0,0,0,0), zero, FULL, "a_idle");

        // Both masters on slave 1 from reset: strict 1,2,1,2 alternation.
        add(st(1,0,0,0,0,0,0), zero, FULL, "b_reset");
        for (int t = 0; t < 8; t++) begin
            add(st(0,1,1,1,1,0,0), (t % 2 == 0) ? g1 : g2, FULL, "b_rr_grant");
            add(st(0,1,1,1,1,1,0), zero, FULL, "b_rr_ack");
        end
        add(st(0,0,0,0,0,0,0), zero, FULL, "b_idle");

        // Crossed concurrent traffic.
        add(st(0,1,1,0,1,0,0), mk(2'b10, 2'b01, 2'b10, 2'b01, 1'b0, 1'b0, 2'b11), FULL, "c_concurrent");
        add(st(0,1,1,0,1,1,1), zero, FULL, "c_both_ack");
        add(st(0,0,0,0,0,0,0), zero, FULL, "c_idle");

        // Watchdog expiry, re-arbitration of a still-held request.
        add(st(0,1,0,1,0,0,0), g1,   FULL, "d_grant");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "d_wait");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "d_wait");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "d_wait");
        add(st(0,1,0,1,0,0,0), mk(2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 2'b01), FULL, "d_timeout_err");
        add(st(0,1,0,1,0,0,0), zero, FULL, "d_err_to_idle");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "d_regrant");
        add(st(0,0,0,0,0,0,0), zero, FULL, "d_abort");

        // Ack on the timeout cycle wins.
        add(st(0,1,0,1,0,0,0), g1,   FULL, "t_grant");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "t_wait");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "t_wait");
        add(st(0,1,0,1,0,0,0), g1,   FULL, "t_wait");
        add(st(0,1,0,1,0,1,0), zero, FULL, "t_ack_beats_timeout");
        add(st(0,0,0,0,0,0,0), zero, FULL, "t_idle");

        // Owner flips a31 mid-grant, then aborts.
        add(st(0,0,1,0,0,0,0), mk(2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 2'b10), FULL, "e_grant");
        add(st(0,0,1,0,1,0,0), mk(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00), EMASK, "e_a31_locked");
        add(st(0,0,1,0,1,0,0), mk(2'b00, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00), EMASK, "e_a31_locked");
        add(st(0,0,0,0,0,0,0), zero, FULL, "e_abort_idle");
        add(st(0,0,0,0,0,0,0), zero, FULL, "e_no_err");

        #1;
        for (int i = 0; i < table_q.size(); i++)
            apply(table_q[i]);

        // Asynchronous reset mid-grant; round-robin pointer must return to master 1.
        apply(mkv(st(0,1,0,1,0,0,0), g1, FULL, "f_grant"));
        #2;
        reset = 1'b1;
        #1;
        check("f_async_reset", outs_w, zero, FULL);
        apply(mkv(st(1,0,0,0,0,0,0), zero, FULL, "f_reset_hold"));
        apply(mkv(st(0,1,1,1,1,0,0), g1, FULL, "f_rr_after_reset"));

        if (sb_q.size() != 0) begin
            total++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
